// File: rtl/mainmem_responder.sv
// Single-port word memory with a fixed-latency, fully pipelined read return path.
// Optional access counters are built when MAINMEM_STATS_EN is defined.
module mainmem_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
`ifdef MAINMEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int DEPTH = 1 << (ADDR_W - 1);
    localparam int LAST  = LATENCY - 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-2:0] word_s;
    logic              addr_unused_s;
    logic              rd_req_s;
    logic              wr_req_s;
    logic [DATA_W-1:0] rd_data_s;

    logic              vld_r [LATENCY];
    logic [DATA_W-1:0] dat_r [LATENCY];

    assign word_s        = addr[ADDR_W-1:1];
    assign addr_unused_s = addr[0];
    assign rd_req_s      = enable & ~wr;
    assign wr_req_s      = enable & wr;
    assign rd_data_s     = mem_r[word_s];

    // Storage array: deliberately not reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_req_s) begin
            mem_r[word_s] <= data_in;
        end
    end

    // Read return pipeline; a stage's data only moves with a valid so the
    // final stage holds its last word across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_r[i] <= 1'b0;
                dat_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= rd_req_s;
            if (rd_req_s) begin
                dat_r[0] <= rd_data_s;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

    assign data_out   = dat_r[LAST];
    assign data_valid = vld_r[LAST];

`ifdef MAINMEM_STATS_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Saturating access counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_r <= 16'd0;
            wr_count_r <= 16'd0;
        end else begin
            if (rd_req_s && (rd_count_r != 16'hFFFF)) begin
                rd_count_r <= rd_count_r + 16'd1;
            end
            if (wr_req_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: doc/mainmem_responder.md
# mainmem_responder

Responder end of the main-memory interface driven by the cache arbiter: accepts one word-wide read or write request per cycle and returns read data after a fixed latency with a `data_valid` strobe. Reads are fully pipelined, so the arbiter can stream a cache-line fill (one address per cycle) and collect the words in order. The block sits below the arbiter and is the only backing store for the instruction and data caches.

## Interface
- `ADDR_W`, 16: byte-address width; word index is `addr[ADDR_W-1:1]`.
- `DATA_W`, 16: word width.
- `LATENCY`, 4: read latency in cycles, legal range 1..8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  request present this cycle.
- `wr`  in  1  1 = write, 0 = read; ignored when `enable`=0.
- `addr`  in  ADDR_W  byte address; bit 0 ignored.
- `data_in`  in  DATA_W  write data, sampled with a write request.
- `data_out`  out  DATA_W  read data, meaningful only while `data_valid`=1.
- `data_valid`  out  1  read data returning this cycle.
- `rd_count`, `wr_count`  out  16 each  access counters (only with `MAINMEM_STATS_EN`).

## Operation
- Storage: 2^(ADDR_W-1) words. Not cleared by reset; contents undefined until written.
- Request accepted on any rising edge with `enable`=1; no back-pressure, one request per cycle always accepted.
- Write: array word `addr[ADDR_W-1:1]` takes `data_in` at the accepting edge. No `data_valid` pulse for writes.
- Read: array word is sampled at the accepting edge and pushed into a LATENCY-deep shift pipeline (valid bit + data). Pipeline advances every cycle unconditionally.
- Read data is snapshot at issue: a write to the same word issued after the read does not alter the in-flight result.
- Read issued in the cycle after a write to the same word returns the new data. Read and write never coincide (single port, `wr` selects).
- Responses return strictly in issue order; gaps in requests produce matching gaps in `data_valid`.
- `enable`=0: no array change, a bubble (valid=0) enters the pipeline.

## Timing
- Read accepted at edge t -> `data_valid`=1 and `data_out`=word during the cycle after edge t+LATENCY-1 (i.e. LATENCY cycles after request presented). LATENCY=4: request in cycle 0, data in cycle 4.
- Back-to-back reads in cycles 0..3 -> `data_valid` high in cycles 4..7, consecutive.
- `data_out` holds its last value when `data_valid`=0 (registered stage output, no combinational path from inputs).
- Reset (`rst_n`=0, any time, including mid-burst): all pipeline valid bits and `data_valid` -> 0, `data_out` -> 0, counters -> 0 immediately (asynchronous). In-flight reads are discarded; no response after release. Array contents retained.
- First request accepted on the first rising edge with `rst_n`=1.

## Configuration
- `MAINMEM_STATS_EN` defined: `rd_count` and `wr_count` ports exist; each increments by 1 on every accepted read / write, saturating at 16'hFFFF, reset to 0.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Write 16'hBEEF to 16'h0010 in cycle 0, read 16'h0010 in cycle 1 -> `data_valid`=1 with 16'hBEEF in cycle 5, `data_valid`=0 in all other cycles.
- Pre-write words 16'h0100..16'h0106 with 16'h1111..16'h4444; reads in cycles 0..3 -> `data_out` 16'h1111,16'h2222,16'h3333,16'h4444 in cycles 4..7.
- Write 16'hAAAA to 16'h0020; read 16'h0020 in cycle 0; write 16'h5555 to 16'h0020 in cycle 1 -> cycle 4 returns 16'hAAAA; new read in cycle 2 returns 16'h5555 in cycle 6.
- Reads issued in cycles 0..2, `rst_n` low in cycle 3 -> `data_valid`, `data_out` 0 immediately; no `data_valid` pulse in any later cycle; previously written words still readable afterward.
- Write 16'h1234 to 16'h0031, read 16'h0030 -> returns 16'h1234 (bit 0 ignored).
- With `MAINMEM_STATS_EN`: 3 writes, 5 reads, 2 idle cycles -> `wr_count`=3, `rd_count`=5; preload counter to saturation by 65536 reads -> stays 16'hFFFF.
